// File: rtl/hit_pkg.sv
// Shared types for the billiard hit-controller pipeline.
//   FRAC_BITS      : fractional bits of velocity (1 LSB = 1/64 px/frame)
//   vel_t          : signed 11-bit velocity, also the width of a pixel coordinate
//   pos_t          : signed fixed-point position, 11 integer + FRAC_BITS fraction bits
//   motion_state_t : ball kinematics state
package hit_pkg;

  localparam int FRAC_BITS = 6;

  typedef logic signed [10:0]           vel_t;
  typedef logic signed [10+FRAC_BITS:0] pos_t;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } motion_state_t;

endpackage

// File: rtl/friction_step.sv
// One friction decrement: moves a velocity component 1 LSB toward zero.
// Purely combinational.
//   vel      : current velocity component
//   vel_next : velocity after one friction step (0 stays 0, -1024 -> -1023)
module friction_step
  import hit_pkg::*;
(
  input  vel_t vel,
  output vel_t vel_next
);

  always_comb begin
    vel_next = vel;
    if (vel > 11'sd0) begin
      vel_next = vel - 11'sd1;
    end else if (vel < 11'sd0) begin
      vel_next = vel + 11'sd1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame kinematics for one billiard ball: accepts a cue shot at rest,
// integrates a saturating fixed-point position once per frame, applies
// periodic friction, and takes reflected velocities from the border stage
// with a holdoff that masks repeat hits from the same contact.
//   clk, resetN            : clock, asynchronous active-low reset
//   startOfFrame           : one-cycle pulse per video frame
//   shotValid/shotVelX/Y   : cue shot request, accepted only at rest
//   collisionOccurred      : border-stage hit flag
//   ballVelXIn/ballVelYIn  : reflected velocity from the border stage
//   topLeftX/topLeftY      : integer pixel position
//   ballVelX/ballVelY      : current velocity (1/64 px/frame)
//   ballMoving             : high while the ball is in motion
module ball_motion #(
  parameter int INIT_X          = 300,
  parameter int INIT_Y          = 220,
  parameter int FRAC_BITS       = hit_pkg::FRAC_BITS,
  parameter int FRICTION_PERIOD = 4,
  parameter int HOLDOFF_FRAMES  = 3
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                shotValid,
  input  logic signed [10:0]  shotVelX,
  input  logic signed [10:0]  shotVelY,
  input  logic                collisionOccurred,
  input  logic signed [10:0]  ballVelXIn,
  input  logic signed [10:0]  ballVelYIn,
  output logic signed [10:0]  topLeftX,
  output logic signed [10:0]  topLeftY,
  output logic signed [10:0]  ballVelX,
  output logic signed [10:0]  ballVelY,
  output logic                ballMoving
);

  import hit_pkg::*;

  localparam int          W          = 11 + FRAC_BITS;
  localparam logic [W-1:0] POS_X_INIT = W'(INIT_X << FRAC_BITS);
  localparam logic [W-1:0] POS_Y_INIT = W'(INIT_Y << FRAC_BITS);
  localparam logic [W-1:0] POS_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] POS_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [7:0]   FRIC_LAST  = 8'(FRICTION_PERIOD - 1);
  localparam logic [7:0]   HOLD_LOAD  = 8'(HOLDOFF_FRAMES);

  motion_state_t state_q, state_d;
  vel_t          vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  vel_t          vel_x_fric, vel_y_fric;
  logic [W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0]    fric_q, fric_d;
  logic [7:0]    hold_q, hold_d;
  logic          coll_accept;
  logic          fric_frame;

  // Position + sign-extended velocity, clamped to the signed position range
  // instead of wrapping: one extra sum bit exposes the overflow.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] pos, input vel_t vel);
    logic [W:0] sum;
    sum = {pos[W-1], pos} + {{(W-10){vel[10]}}, vel};
    if (sum[W] != sum[W-1]) begin
      return sum[W] ? POS_MIN : POS_MAX;
    end
    return sum[W-1:0];
  endfunction

  friction_step u_fric_x (.vel(vel_x_q), .vel_next(vel_x_fric));
  friction_step u_fric_y (.vel(vel_y_q), .vel_next(vel_y_fric));

  always_comb begin
    // NOTE: every variable driven here gets its hold value first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    fric_d      = fric_q;
    hold_d      = hold_q;
    coll_accept = 1'b0;
    fric_frame  = 1'b0;

    case (state_q)
      IDLE: begin
        // A zero shot would immediately stop again; treat it as no shot.
        if (shotValid && (shotVelX != '0 || shotVelY != '0)) begin
          state_d = MOVING;
          vel_x_d = shotVelX;
          vel_y_d = shotVelY;
        end
      end

      MOVING: begin
        coll_accept = collisionOccurred && (hold_q == '0);

        if (startOfFrame) begin
          // Integrate with the velocity held before this cycle, even when a
          // collision replaces it in the same cycle.
          pos_x_d    = sat_add(pos_x_q, vel_x_q);
          pos_y_d    = sat_add(pos_y_q, vel_y_q);
          fric_frame = (fric_q == FRIC_LAST);
          fric_d     = fric_frame ? 8'd0 : fric_q + 8'd1;
          if (fric_frame && !coll_accept) begin
            vel_x_d = vel_x_fric;
            vel_y_d = vel_y_fric;
          end
          if (hold_q != '0) begin
            hold_d = hold_q - 8'd1;
          end
        end

        // A fresh collision overrides both friction and the holdoff decrement.
        if (coll_accept) begin
          vel_x_d = ballVelXIn;
          vel_y_d = ballVelYIn;
          hold_d  = HOLD_LOAD;
        end

        // Stopping is decided only at a frame update.
        if (startOfFrame && vel_x_d == '0 && vel_y_d == '0) begin
          state_d = IDLE;
          fric_d  = '0;
          hold_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      vel_x_q <= '0;
      vel_y_q <= '0;
      pos_x_q <= POS_X_INIT;
      pos_y_q <= POS_Y_INIT;
      fric_q  <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      vel_x_q <= vel_x_d;
      vel_y_q <= vel_y_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      fric_q  <= fric_d;
      hold_q  <= hold_d;
    end
  end

  assign topLeftX   = pos_x_q[FRAC_BITS +: 11];
  assign topLeftY   = pos_y_q[FRAC_BITS +: 11];
  assign ballVelX   = vel_x_q;
  assign ballVelY   = vel_y_q;
  assign ballMoving = (state_q == MOVING);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios with hand-computed
// expectations, then randomized traffic checked every cycle against a
// behavioural model kept in plain integer arithmetic.
module tb_ball_motion;

  localparam int P       = 4;
  localparam int H       = 3;
  localparam int INIT_X  = 300;
  localparam int INIT_Y  = 220;
  localparam int POS_MIN = -65536;
  localparam int POS_MAX = 65535;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               shotValid;
  logic signed [10:0] shotVelX, shotVelY;
  logic               collisionOccurred;
  logic signed [10:0] ballVelXIn, ballVelYIn;
  logic signed [10:0] topLeftX, topLeftY;
  logic signed [10:0] ballVelX, ballVelY;
  logic               ballMoving;

  int n_checks = 0;
  int n_passed = 0;

  ball_motion #(
    .INIT_X(INIT_X), .INIT_Y(INIT_Y), .FRAC_BITS(6),
    .FRICTION_PERIOD(P), .HOLDOFF_FRAMES(H)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .shotValid(shotValid), .shotVelX(shotVelX), .shotVelY(shotVelY),
    .collisionOccurred(collisionOccurred),
    .ballVelXIn(ballVelXIn), .ballVelYIn(ballVelYIn),
    .topLeftX(topLeftX), .topLeftY(topLeftY),
    .ballVelX(ballVelX), .ballVelY(ballVelY), .ballMoving(ballMoving)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Friction is applied on every P-th frame counted since the shot; a
  // collision is honoured once at least H frames have passed since the last
  // honoured one.
  bit m_moving;
  int m_vx, m_vy, m_px, m_py;
  int m_frames, m_last_hit;

  function automatic int toward_zero(input int v);
    return (v > 0) ? v - 1 : ((v < 0) ? v + 1 : 0);
  endfunction

  function automatic int clamp_pos(input int p);
    return (p > POS_MAX) ? POS_MAX : ((p < POS_MIN) ? POS_MIN : p);
  endfunction

  task automatic model_reset();
    m_moving   = 1'b0;
    m_vx       = 0;
    m_vy       = 0;
    m_px       = INIT_X * 64;
    m_py       = INIT_Y * 64;
    m_frames   = 0;
    m_last_hit = -1000;
  endtask

  task automatic model_step();
    int  nvx, nvy;
    bit  hit;
    if (!m_moving) begin
      if (shotValid && (shotVelX != 0 || shotVelY != 0)) begin
        m_moving   = 1'b1;
        m_vx       = int'(shotVelX);
        m_vy       = int'(shotVelY);
        m_frames   = 0;
        m_last_hit = -1000;
      end
    end else begin
      hit = collisionOccurred && (m_frames - m_last_hit >= H);
      nvx = m_vx;
      nvy = m_vy;
      if (startOfFrame) begin
        m_px = clamp_pos(m_px + m_vx);
        m_py = clamp_pos(m_py + m_vy);
        m_frames++;
        if (m_frames % P == 0) begin
          nvx = toward_zero(m_vx);
          nvy = toward_zero(m_vy);
        end
      end
      if (hit) begin
        nvx        = int'(ballVelXIn);
        nvy        = int'(ballVelYIn);
        m_last_hit = m_frames;
      end
      m_vx = nvx;
      m_vy = nvy;
      if (startOfFrame && m_vx == 0 && m_vy == 0) m_moving = 1'b0;
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) model_reset();
    else         model_step();
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cmp_topLeftX", int'(topLeftX), m_px >>> 6);
    check("cmp_topLeftY", int'(topLeftY), m_py >>> 6);
    check("cmp_ballVelX", int'(ballVelX), m_vx);
    check("cmp_ballVelY", int'(ballVelY), m_vy);
    check("cmp_ballMoving", int'(ballMoving), int'(m_moving));
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; holds the inputs for one cycle.
  task automatic drive(input bit sof, input bit shot, input bit coll,
                       input int sx = 0, input int sy = 0,
                       input int cx = 0, input int cy = 0);
    startOfFrame      = sof;
    shotValid         = shot;
    collisionOccurred = coll;
    shotVelX          = 11'(sx);
    shotVelY          = 11'(sy);
    ballVelXIn        = 11'(cx);
    ballVelYIn        = 11'(cy);
    @(negedge clk);
    startOfFrame      = 1'b0;
    shotValid         = 1'b0;
    collisionOccurred = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges, checks the outputs with no clock edge in
  // between, and releases at the next falling edge.
  task automatic do_reset(input string tag);
    #2 resetN = 1'b0;
    #1;
    check({tag, "_rst_x"}, int'(topLeftX), 300);
    check({tag, "_rst_y"}, int'(topLeftY), 220);
    check({tag, "_rst_vx"}, int'(ballVelX), 0);
    check({tag, "_rst_vy"}, int'(ballVelY), 0);
    check({tag, "_rst_moving"}, int'(ballMoving), 0);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic int rand_vel();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return -1024;
      2:       return 1023;
      3:       return int'($urandom_range(0, 6)) - 3;
      default: return int'($urandom_range(0, 2047)) - 1024;
    endcase
  endfunction

  initial begin
    int cx, cy;
    model_reset();
    resetN            = 1'b0;
    startOfFrame      = 1'b0;
    shotValid         = 1'b0;
    collisionOccurred = 1'b0;
    shotVelX          = '0;
    shotVelY          = '0;
    ballVelXIn        = '0;
    ballVelYIn        = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;

    // Reset state survives a frame with no shot; a zero shot is ignored.
    frames(1);
    check("idle_x", int'(topLeftX), 300);
    check("idle_y", int'(topLeftY), 220);
    check("idle_moving", int'(ballMoving), 0);
    check("idle_vx", int'(ballVelX), 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    check("zero_shot_moving", int'(ballMoving), 0);

    // Shot (64,-128): one frame moves (+1,-2) px; friction on frame 4.
    drive(1'b0, 1'b1, 1'b0, 64, -128);
    check("shot_vx", int'(ballVelX), 64);
    check("shot_vy", int'(ballVelY), -128);
    check("shot_moving", int'(ballMoving), 1);
    frames(1);
    check("f1_x", int'(topLeftX), 301);
    check("f1_y", int'(topLeftY), 218);
    frames(2);
    check("f3_vx", int'(ballVelX), 64);
    frames(1);
    check("f4_vx", int'(ballVelX), 63);
    check("f4_vy", int'(ballVelY), -127);

    // Collision accepted, repeat within holdoff dropped, later one accepted.
    drive(1'b0, 1'b0, 1'b1, 0, 0, -64, -127);
    check("coll1_vx", int'(ballVelX), -64);
    frames(1);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 100, -127);
    check("coll_holdoff_vx", int'(ballVelX), -64);
    frames(2);
    drive(1'b0, 1'b0, 1'b1, 0, 0, 50, -127);
    check("coll_after_vx", int'(ballVelX), 50);

    do_reset("mid");

    // Frame and collision together on a friction frame: old velocity
    // integrates, collision velocity loads, no friction.
    drive(1'b0, 1'b1, 1'b0, 64, 0);
    frames(3);
    check("same_pre_x", int'(topLeftX), 303);
    drive(1'b1, 1'b0, 1'b1, 0, 0, -64, 0);
    check("same_x", int'(topLeftX), 304);
    check("same_vx", int'(ballVelX), -64);
    check("same_moving", int'(ballMoving), 1);

    do_reset("b");

    // Shot (2,0) decays to zero on frame 8; shots while moving are ignored.
    drive(1'b0, 1'b1, 1'b0, 2, 0);
    frames(7);
    check("decay_f7_vx", int'(ballVelX), 1);
    check("decay_f7_moving", int'(ballMoving), 1);
    drive(1'b0, 1'b1, 1'b0, 100, 100);
    check("shot_ignored_vx", int'(ballVelX), 1);
    frames(1);
    check("decay_f8_vx", int'(ballVelX), 0);
    check("decay_f8_moving", int'(ballMoving), 0);
    check("decay_x", int'(topLeftX), 300);
    drive(1'b0, 1'b1, 1'b0, 5, 0);
    check("reshot_moving", int'(ballMoving), 1);
    check("reshot_vx", int'(ballVelX), 5);

    do_reset("c");

    // Extreme velocities: -1024 friction boundary and position saturation.
    drive(1'b0, 1'b1, 1'b0, 1023, -1024);
    frames(4);
    check("ext_vx", int'(ballVelX), 1022);
    check("ext_vy", int'(ballVelY), -1023);
    frames(120);
    check("sat_x", int'(topLeftX), 1023);
    check("sat_y", int'(topLeftY), -1024);

    do_reset("d");

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cx = 0;
        cy = 0;
      end else begin
        cx = rand_vel();
        cy = rand_vel();
      end
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0, rand_vel(), rand_vel(), cx, cy);
      if (i % 5000 == 4999) do_reset("rnd");
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
